// File: rtl/overlay_fetch.sv
// Overlay pixel prefetcher: streams pixel words from memory into a small FIFO
// and pops one word per active pixel onto registered ovl_* outputs.
module overlay_fetch #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vsync,
    input  logic [1:0]        step,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [4*CH_W-1:0] mem_data,
    output logic [CH_W-1:0]   ovl_r,
    output logic [CH_W-1:0]   ovl_g,
    output logic [CH_W-1:0]   ovl_b,
    output logic [CH_W-1:0]   ovl_a,
    output logic              underrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 4 * CH_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              outst_q, outst_d, stale_q, stale_d, vs_prev_q, vs_prev_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d, mem_addr_q, mem_addr_d, stride_inc;
    logic [1:0]        stride_q, stride_d;
    logic              mem_req_q, mem_req_d, underrun_q, underrun_d;
    logic [DW-1:0]     ovl_q, ovl_d;
    logic              frame_start, flush, active, empty, rsp, wr, pop, issue;

    always_comb begin
        frame_start = ce_pix & vsync & ~vs_prev_q;
        flush       = frame_start | ~enable;
        active      = ce_pix & ~hblank & ~vblank;
        empty       = (count_q == '0);
        rsp         = mem_valid & outst_q;
        wr          = rsp & ~stale_q & ~flush;
        pop         = active & ~flush & ~empty;
        // a full FIFO blocks issue, so a write can never land on a full FIFO
        issue       = enable & ~outst_q & (count_q < DEPTH_C) & ~flush;
        case (stride_q)
            2'd1:    stride_inc = ADDR_W'(4);
            2'd2:    stride_inc = ADDR_W'(8);
            default: stride_inc = ADDR_W'(2);
        endcase
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(wr);
        count_d     = count_q + CW'(wr) - CW'(pop);
        outst_d     = outst_q;
        stale_d     = stale_q;
        next_addr_d = next_addr_q;
        stride_d    = stride_q;
        vs_prev_d   = ce_pix ? vsync : vs_prev_q;
        mem_req_d   = issue;
        mem_addr_d  = issue ? next_addr_q : mem_addr_q;
        ovl_d       = ovl_q;
        underrun_d  = underrun_q;
        if (rsp) begin
            outst_d = 1'b0;
            stale_d = 1'b0;
        end
        if (issue) begin
            outst_d     = 1'b1;
            next_addr_d = next_addr_q + stride_inc;
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (outst_q & ~rsp) stale_d = 1'b1;
        end
        if (frame_start) begin
            next_addr_d = '0;
            stride_d    = step;
            underrun_d  = 1'b0;
        end
        // flush wins over a same-cycle pop: the pixel shows 0 and no underrun is flagged
        if (~enable | (ce_pix & (hblank | vblank))) begin
            ovl_d = '0;
        end else if (active) begin
            ovl_d = (frame_start | empty) ? '0 : fifo_q[rd_ptr_q];
            if (~frame_start & empty) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= 1'b0;
            stale_q     <= 1'b0;
            vs_prev_q   <= 1'b0;
            next_addr_q <= '0;
            stride_q    <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ovl_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            stale_q     <= stale_d;
            vs_prev_q   <= vs_prev_d;
            next_addr_q <= next_addr_d;
            stride_q    <= stride_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ovl_q       <= ovl_d;
            underrun_q  <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) fifo_q[wr_ptr_q] <= mem_data;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;
    assign ovl_r    = ovl_q[CH_W-1:0];
    assign ovl_g    = ovl_q[2*CH_W-1:CH_W];
    assign ovl_b    = ovl_q[3*CH_W-1:2*CH_W];
    assign ovl_a    = ovl_q[4*CH_W-1:3*CH_W];
endmodule

// File: tb/tb_overlay_fetch.sv
// Bench for overlay_fetch: queue-based reference model plus a latency-driven
// memory responder, directed frame scenarios, then a randomized run.
module tb_overlay_fetch;
    localparam int AW = 5, DEPTH = 8, CH = 4, PW = 4 * CH;

    logic          clk = 1'b0;
    logic          reset, enable, ce_pix, hblank, vblank, vsync;
    logic [1:0]    step;
    logic          mem_req, mem_valid, underrun;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data;
    logic [CH-1:0] ovl_r, ovl_g, ovl_b, ovl_a;

    always #5 clk = ~clk;

    overlay_fetch #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CH_W(CH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vsync(vsync), .step(step),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_data(mem_data), .ovl_r(ovl_r), .ovl_g(ovl_g), .ovl_b(ovl_b),
        .ovl_a(ovl_a), .underrun(underrun)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // memory responder: each request returns a random word lat cycles later
    typedef struct { int due; logic [AW-1:0] addr; } rsp_t;
    rsp_t          mq[$];
    int            lat = 3, cyc = 0;
    logic [PW-1:0] word_by_addr [32];
    logic [AW-1:0] addr_log[$];
    logic [PW-1:0] pix_log[$];

    // reference model: FIFO as a queue, one outstanding read, frame rules
    logic [PW-1:0] m_q[$];
    bit            m_out, m_stale, m_vsp;
    int            m_next, m_stride;
    bit            e_req, e_und;
    int            e_addr;
    logic [PW-1:0] e_ovl;

    task automatic model_step();
        bit fs, flush, act, rsp, issue;
        if (reset) begin
            m_q.delete();
            m_out = 0; m_stale = 0; m_vsp = 0; m_next = 0; m_stride = 2;
            e_req = 0; e_addr = 0; e_ovl = '0; e_und = 0;
            return;
        end
        fs    = ce_pix && vsync && !m_vsp;
        flush = fs || !enable;
        act   = ce_pix && !hblank && !vblank;
        rsp   = mem_valid && m_out;
        issue = enable && !m_out && (m_q.size() < DEPTH) && !flush;
        e_req = issue;
        if (issue) e_addr = m_next;
        if (!enable || (ce_pix && (hblank || vblank)) || (act && fs)) e_ovl = '0;
        else if (act) begin
            if (m_q.size() == 0) begin e_ovl = '0; e_und = 1; end
            else e_ovl = m_q.pop_front();
        end
        if (flush) begin
            m_q.delete();
            if (m_out && !rsp) m_stale = 1;
        end else if (rsp && !m_stale) m_q.push_back(mem_data);
        if (rsp) begin m_out = 0; m_stale = 0; end
        if (issue) begin m_out = 1; m_next = (m_next + m_stride) % (1 << AW); end
        if (fs) begin
            m_next = 0;
            m_stride = (step == 2'd1) ? 4 : (step == 2'd2) ? 8 : 2;
            e_und = 0;
        end
        if (ce_pix) m_vsp = vsync;
    endtask

    task automatic tick();
        bit   act;
        rsp_t r;
        cyc++;
        mem_valid = 1'b0;
        mem_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            mem_valid = 1'b1;
            mem_data  = PW'($urandom);
            word_by_addr[r.addr] = mem_data;
        end
        act = !reset && enable && ce_pix && !hblank && !vblank;
        model_step();
        @(posedge clk); #1;
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("ovl", 32'({ovl_a, ovl_b, ovl_g, ovl_r}), 32'(e_ovl));
        chk("underrun", 32'(underrun), 32'(e_und));
        if (mem_req) begin
            mq.push_back('{cyc + lat, mem_addr});
            addr_log.push_back(mem_addr);
        end
        if (act) pix_log.push_back({ovl_a, ovl_b, ovl_g, ovl_r});
    endtask

    task automatic run_blank(input int n);
        for (int i = 0; i < n; i++) begin
            ce_pix = 1; hblank = 0; vblank = 1; vsync = 0;
            tick();
        end
    endtask

    task automatic run_active(input int n, input int k);
        for (int i = 0; i < n; i++) begin
            ce_pix = (i % k == 0); hblank = 0; vblank = 0; vsync = 0;
            tick();
        end
    endtask

    task automatic vsync_edge();
        ce_pix = 1; hblank = 0; vblank = 1; vsync = 0;
        tick();
        vsync = 1;
        tick();
        addr_log.delete();
        pix_log.delete();
        vsync = 0;
        tick();
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        reset = 1; enable = 0; ce_pix = 0; hblank = 0; vblank = 1; vsync = 0;
        step = 0; mem_valid = 0; mem_data = '0;
        tick(); tick();
        reset = 0;
        run_blank(5);

        // steady state, stride +2, latency 3
        enable = 1; lat = 3; step = 0;
        vsync_edge();
        run_blank(60);
        chk("st_nreq", 32'(addr_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) chk("st_addr", log_at(i), 32'(2 * i));
        pix_log.delete();
        run_active(4, 1);
        for (int i = 0; i < 4; i++)
            chk("st_pix", (i < pix_log.size()) ? 32'(pix_log[i]) : 32'hFFFF_FFFF,
                32'(word_by_addr[2 * i]));
        chk("st_und", 32'(underrun), 32'd0);

        // stride latched at frame start, later step changes are ignored
        step = 2;
        vsync_edge();
        step = 0;
        run_blank(40);
        for (int i = 0; i < 4; i++) chk("stride_addr", log_at(i), 32'(8 * i));

        // address wrap with stride +4
        step = 1;
        vsync_edge();
        for (int n = 0; n < 400 && addr_log.size() < 9; n++) begin
            ce_pix = (n % 2 == 0); hblank = 0; vblank = 0; vsync = 0;
            tick();
        end
        for (int i = 0; i < 9; i++) chk("wrap_addr", log_at(i), 32'((4 * i) % 32));

        // starvation with slow memory
        step = 0; lat = 40;
        vsync_edge();
        run_active(100, 1);
        chk("starve_und", 32'(underrun), 32'd1);
        chk("starve_pix", (pix_log.size() > 0) ? 32'(pix_log[0]) : 32'hFFFF_FFFF, 32'd0);
        vsync_edge();
        chk("starve_clr", 32'(underrun), 32'd0);

        // frame start while a request is outstanding
        lat = 20;
        addr_log.delete();
        for (int n = 0; n < 200 && addr_log.size() == 0; n++) run_blank(1);
        run_blank(3);
        vsync_edge();
        lat = 2;
        run_active(10, 1);
        chk("mid_und", 32'(underrun), 32'd1);
        chk("mid_pix", (pix_log.size() == 10) ? 32'(pix_log[9]) : 32'hFFFF_FFFF, 32'd0);
        addr_log.delete();
        run_blank(40);
        chk("mid_addr0", log_at(0), 32'd0);

        // reset with a full FIFO
        lat = 1;
        vsync_edge();
        run_blank(40);
        run_active(1, 1);
        reset = 1; #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ovl", 32'({ovl_a, ovl_b, ovl_g, ovl_r}), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        tick();
        reset = 0; enable = 0;
        addr_log.delete();
        run_blank(10);
        chk("rst_noreq", 32'(addr_log.size()), 32'd0);
        enable = 1;
        vsync_edge();
        run_blank(20);
        chk("rst_addr0", log_at(0), 32'd0);

        // randomized frames
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 12);
            if ($urandom_range(0, 299) == 0) enable = !enable;
            reset  = ($urandom_range(0, 799) == 0);
            step   = 2'($urandom);
            ce_pix = ($urandom_range(0, 3) != 0);
            hblank = ($urandom_range(0, 3) == 0);
            vblank = ((i % 200) < 20);
            vsync  = ((i % 200) >= 5) && ((i % 200) < 9);
            tick();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
